stage_wb: RTL

//  Write-back stage: MEM/WB pipeline register plus load-data formatting and result select.

---
 rtl/stage_wb_if.sv | 62 ++++++
 rtl/stage_wb.sv | 109 ++++++++++
 2 files changed

// File: rtl/stage_wb_if.sv
// MEM/WB handshake bundle and register-file write port of stage_wb.
// Bypass signals exist only when WB_BYPASS_EN is defined.
interface stage_wb_if #(
   parameter int CNT_W = 32
);
   logic             Stall_WB;
   logic             Flush_WB;
   logic             Valid_in_WB;
   logic             RegWrite_in_WB;
   logic             MemtoReg_in_WB;
   logic [2:0]       LoadType_in_WB;
   logic [31:0]      ALUResult_in_WB;
   logic [31:0]      MemReadData_in_WB;
   logic [4:0]       WriteRegister_in_WB;
   logic             RegWrite_out_WB;
   logic [4:0]       WriteRegister_out_WB;
   logic [31:0]      WriteData_out_WB;
   logic [CNT_W-1:0] RetireCount_WB;
`ifdef WB_BYPASS_EN
   logic             BypassValid_WB;
   logic [4:0]       BypassReg_WB;
   logic [31:0]      BypassData_WB;

   modport master (
      output Stall_WB, Flush_WB, Valid_in_WB,
      output RegWrite_in_WB, MemtoReg_in_WB,
      output LoadType_in_WB, ALUResult_in_WB,
      output MemReadData_in_WB, WriteRegister_in_WB,
      input  RegWrite_out_WB, WriteRegister_out_WB,
      input  WriteData_out_WB, RetireCount_WB,
      input  BypassValid_WB, BypassReg_WB,
      input  BypassData_WB
   );
   modport slave (
      input  Stall_WB, Flush_WB, Valid_in_WB,
      input  RegWrite_in_WB, MemtoReg_in_WB,
      input  LoadType_in_WB, ALUResult_in_WB,
      input  MemReadData_in_WB, WriteRegister_in_WB,
      output RegWrite_out_WB, WriteRegister_out_WB,
      output WriteData_out_WB, RetireCount_WB,
      output BypassValid_WB, BypassReg_WB,
      output BypassData_WB
   );
`else
   modport master (
      output Stall_WB, Flush_WB, Valid_in_WB,
      output RegWrite_in_WB, MemtoReg_in_WB,
      output LoadType_in_WB, ALUResult_in_WB,
      output MemReadData_in_WB, WriteRegister_in_WB,
      input  RegWrite_out_WB, WriteRegister_out_WB,
      input  WriteData_out_WB, RetireCount_WB
   );
   modport slave (
      input  Stall_WB, Flush_WB, Valid_in_WB,
      input  RegWrite_in_WB, MemtoReg_in_WB,
      input  LoadType_in_WB, ALUResult_in_WB,
      input  MemReadData_in_WB, WriteRegister_in_WB,
      output RegWrite_out_WB, WriteRegister_out_WB,
      output WriteData_out_WB, RetireCount_WB
   );
`endif
endinterface

// File: rtl/stage_wb.sv
// Write-back stage: MEM/WB register, load formatting, retire counter.
// Optional registered bypass outputs under macro WB_BYPASS_EN.
module stage_wb #(
   parameter int CNT_W = 32
) (
   input logic       Clk,
   input logic       Reset,
   stage_wb_if.slave wb
);
   logic             valid_q;
   logic             regwrite_q;
   logic             memtoreg_q;
   logic [2:0]       loadtype_q;
   logic [31:0]      alu_q;
   logic [31:0]      rdata_q;
   logic [4:0]       wreg_q;
   logic [CNT_W-1:0] count_q;

   logic             we;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [31:0]      load_data;
   logic [31:0]      wdata;

   always_ff @(posedge Clk) begin
      if (Reset || wb.Flush_WB) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         loadtype_q <= 3'd0;
         alu_q      <= 32'd0;
         rdata_q    <= 32'd0;
         wreg_q     <= 5'd0;
      end else if (!wb.Stall_WB) begin
         valid_q    <= wb.Valid_in_WB;
         regwrite_q <= wb.RegWrite_in_WB;
         memtoreg_q <= wb.MemtoReg_in_WB;
         loadtype_q <= wb.LoadType_in_WB;
         alu_q      <= wb.ALUResult_in_WB;
         rdata_q    <= wb.MemReadData_in_WB;
         wreg_q     <= wb.WriteRegister_in_WB;
      end
   end

   // A stalled writer is counted once, on the edge it leaves.
   always_ff @(posedge Clk) begin
      if (Reset)
         count_q <= '0;
      else if (we && !wb.Stall_WB)
         count_q <= count_q + 1'b1;
   end

   assign we = valid_q && regwrite_q && (wreg_q != 5'd0);

   always_comb begin
      byte_sel = 8'd0;
      unique case (alu_q[1:0])
         2'd0: byte_sel = rdata_q[7:0];
         2'd1: byte_sel = rdata_q[15:8];
         2'd2: byte_sel = rdata_q[23:16];
         2'd3: byte_sel = rdata_q[31:24];
         default: byte_sel = 8'd0;
      endcase
   end

   assign half_sel = alu_q[1] ? rdata_q[31:16]
                              : rdata_q[15:0];

   always_comb begin
      load_data = rdata_q;
      case (loadtype_q)
         3'd1: load_data = {{16{half_sel[15]}}, half_sel};
         3'd2: load_data = {16'd0, half_sel};
         3'd3: load_data = {{24{byte_sel[7]}}, byte_sel};
         3'd4: load_data = {24'd0, byte_sel};
         default: load_data = rdata_q;
      endcase
   end

   assign wdata = memtoreg_q ? load_data : alu_q;

   assign wb.RegWrite_out_WB      = we;
   assign wb.WriteRegister_out_WB = wreg_q;
   assign wb.WriteData_out_WB     = wdata;
   assign wb.RetireCount_WB       = count_q;

`ifdef WB_BYPASS_EN
   logic        byp_valid_q;
   logic [4:0]  byp_reg_q;
   logic [31:0] byp_data_q;

   // Updates even while stalled so ID/EX sees last cycle's commit.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         byp_valid_q <= 1'b0;
         byp_reg_q   <= 5'd0;
         byp_data_q  <= 32'd0;
      end else begin
         byp_valid_q <= we;
         byp_reg_q   <= wreg_q;
         byp_data_q  <= wdata;
      end
   end

   assign wb.BypassValid_WB = byp_valid_q;
   assign wb.BypassReg_WB   = byp_reg_q;
   assign wb.BypassData_WB  = byp_data_q;
`endif
endmodule
